// File: rtl/comp_pkg.sv
// Shared widths, FSM state type and frame-length clamp for the complex accumulator.
package comp_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACC,
      OUT
   } state_e;

   // Width of one sign-extended multiplier output field.
   function automatic int iw(input int dwidth);
      return 2 * dwidth + 2;
   endfunction

   // Width of one accumulator field: input width plus guard bits.
   function automatic int aw(input int dwidth, input int acc_ext);
      return iw(dwidth) + acc_ext;
   endfunction

   // A zero length means a single-product frame; anything beyond the guard
   // bits' reach is cut to the longest frame that cannot overflow.
   function automatic int clamp_len(input int len, input int acc_ext);
      int max_len;
      max_len = 1 << acc_ext;
      if (len == 0) begin
         return 1;
      end else if (len > max_len) begin
         return max_len;
      end else begin
         return len;
      end
   endfunction

endpackage

// File: rtl/comp_acc_lane.sv
// One signed accumulator lane: load, add or clear a sign-extended input field.
module comp_acc_lane
#(
   parameter int IW = 18,
   parameter int AW = 22
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clr_i,
   input  logic                 load_i,
   input  logic                 add_i,
   input  logic signed [IW-1:0] din_i,
   output logic signed [AW-1:0] acc_o
);

   logic signed [AW-1:0] din_ext;
   logic signed [AW-1:0] acc_d;
   logic signed [AW-1:0] acc_q;

   // Next accumulator value; clear beats load beats add.
   always_comb begin
      // NOTE: assign a default before any branch so no path leaves acc_d unassigned and a latch is never inferred.
      acc_d   = acc_q;
      din_ext = {{(AW - IW){din_i[IW-1]}}, din_i};
      if (clr_i) begin
         acc_d = '0;
      end else if (load_i) begin
         acc_d = din_ext;
      end else if (add_i) begin
         acc_d = acc_q + din_ext;
      end
   end

   // Accumulator register with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/comp_acc.sv
// Complex accumulator: sums a frame of complex products and holds the result until accepted.
module comp_acc
   import comp_pkg::*;
#(
   parameter int DWIDTH  = 8,
   parameter int ACC_EXT = 4
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                sw_rst,
   input  logic [ACC_EXT:0]                    acc_len,
   input  logic                                in_val,
   output logic                                in_rdy,
   input  logic [2*iw(DWIDTH)-1:0]             in_data,
   output logic                                acc_val,
   input  logic                                acc_rdy,
   output logic [2*aw(DWIDTH, ACC_EXT)-1:0]    acc_data,
   output logic [ACC_EXT:0]                    acc_cnt
);

   localparam int IW = iw(DWIDTH);
   localparam int AW = aw(DWIDTH, ACC_EXT);
   localparam int LW = ACC_EXT + 1;

   state_e               state_q;
   logic [LW-1:0]        len_q;
   logic [LW-1:0]        len_d;
   logic [LW-1:0]        cnt_q;
   logic [LW-1:0]        cnt_d;
   logic                 acc_val_q;
   logic                 in_fire;
   logic                 lane_load;
   logic                 lane_add;
   logic signed [AW-1:0] xs;
   logic signed [AW-1:0] ys;

   assign in_rdy    = (state_q != OUT);
   assign in_fire   = in_val & in_rdy;
   assign len_d     = LW'(clamp_len(int'(acc_len), ACC_EXT));
   assign cnt_d     = cnt_q + LW'(1);
   assign lane_load = in_fire && (state_q == IDLE);
   assign lane_add  = in_fire && (state_q == ACC);

   // Frame control: length latch, product count, state and result-valid flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         len_q     <= LW'(1);
         cnt_q     <= '0;
         acc_val_q <= 1'b0;
      end else if (sw_rst) begin
         state_q   <= IDLE;
         len_q     <= LW'(1);
         cnt_q     <= '0;
         acc_val_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_fire) begin
                  len_q <= len_d;
                  cnt_q <= LW'(1);
                  if (len_d == LW'(1)) begin
                     state_q   <= OUT;
                     acc_val_q <= 1'b1;
                  end else begin
                     state_q <= ACC;
                  end
               end
            end
            ACC: begin
               if (in_fire) begin
                  cnt_q <= cnt_d;
                  if (cnt_d == len_q) begin
                     state_q   <= OUT;
                     acc_val_q <= 1'b1;
                  end
               end
            end
            OUT: begin
               if (acc_rdy) begin
                  state_q   <= IDLE;
                  cnt_q     <= '0;
                  acc_val_q <= 1'b0;
               end
            end
            default: begin
               state_q   <= IDLE;
               acc_val_q <= 1'b0;
            end
         endcase
      end
   end

   comp_acc_lane #(.IW(IW), .AW(AW)) u_lane_re (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (sw_rst),
      .load_i (lane_load),
      .add_i  (lane_add),
      .din_i  (in_data[2*IW-1:IW]),
      .acc_o  (xs)
   );

   comp_acc_lane #(.IW(IW), .AW(AW)) u_lane_im (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (sw_rst),
      .load_i (lane_load),
      .add_i  (lane_add),
      .din_i  (in_data[IW-1:0]),
      .acc_o  (ys)
   );

   assign acc_val  = acc_val_q;
   assign acc_cnt  = cnt_q;
   assign acc_data = {xs, ys};

endmodule

// File: tb/tb_comp_acc.sv
// Bench for comp_acc: frame-level model compared every cycle, plus directed literal checks.
module tb_comp_acc;

   localparam int DW = 8;
   localparam int AE = 4;
   localparam int IW = 2 * DW + 2;
   localparam int AW = IW + AE;
   localparam int MAXLEN = 1 << AE;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              sw_rst = 1'b0;
   logic [AE:0]       acc_len = '0;
   logic              in_val = 1'b0;
   logic              in_rdy;
   logic [2*IW-1:0]   in_data = '0;
   logic              acc_val;
   logic              acc_rdy = 1'b0;
   logic [2*AW-1:0]   acc_data;
   logic [AE:0]       acc_cnt;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   // Frame-level reference: running complex sum, products taken, frame length, result pending.
   int m_xs = 0;
   int m_ys = 0;
   int m_cnt = 0;
   int m_len = 1;
   bit m_hold = 1'b0;

   always #5 clk = ~clk;

   comp_acc #(.DWIDTH(DW), .ACC_EXT(AE)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .sw_rst   (sw_rst),
      .acc_len  (acc_len),
      .in_val   (in_val),
      .in_rdy   (in_rdy),
      .in_data  (in_data),
      .acc_val  (acc_val),
      .acc_rdy  (acc_rdy),
      .acc_data (acc_data),
      .acc_cnt  (acc_cnt)
   );

   task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic signed [63:0] xs_of();
      logic signed [AW-1:0] f;
      f = acc_data[2*AW-1:AW];
      return f;
   endfunction

   function automatic logic signed [63:0] ys_of();
      logic signed [AW-1:0] f;
      f = acc_data[AW-1:0];
      return f;
   endfunction

   // Reference update: frames are lists of products summed with plain integers.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n || sw_rst) begin
         m_xs = 0; m_ys = 0; m_cnt = 0; m_len = 1; m_hold = 1'b0;
      end else if (m_hold) begin
         if (acc_rdy) begin
            m_hold = 1'b0;
            m_cnt  = 0;
         end
      end else if (in_val) begin
         if (m_cnt == 0) begin
            m_len = (acc_len == 0) ? 1 : ((int'(acc_len) > MAXLEN) ? MAXLEN : int'(acc_len));
            m_xs  = 0;
            m_ys  = 0;
         end
         m_xs  += int'($signed(in_data[2*IW-1:IW]));
         m_ys  += int'($signed(in_data[IW-1:0]));
         m_cnt += 1;
         if (m_cnt == m_len) m_hold = 1'b1;
      end
   end

   // Every-cycle comparison against the reference, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_in_rdy",  in_rdy,  !m_hold);
         check("cyc_acc_val", acc_val, m_hold);
         check("cyc_acc_cnt", acc_cnt, m_cnt);
         check("cyc_xs",      xs_of(), m_xs);
         check("cyc_ys",      ys_of(), m_ys);
      end
   end

   task automatic drive(input int xr, input int yr, input int len);
      in_val  = 1'b1;
      in_data = {IW'(xr), IW'(yr)};
      acc_len = (AE + 1)'(len);
      @(negedge clk);
   endtask

   task automatic handshake(input string tag);
      in_val  = 1'b0;
      acc_rdy = 1'b1;
      @(negedge clk);
      acc_rdy = 1'b0;
      check({tag, "_hs_in_rdy"},  in_rdy,  1);
      check({tag, "_hs_acc_val"}, acc_val, 0);
      check({tag, "_hs_acc_cnt"}, acc_cnt, 0);
   endtask

   task automatic expect_result(input string tag, input int xs, input int ys, input int cnt);
      check({tag, "_acc_val"}, acc_val, 1);
      check({tag, "_in_rdy"},  in_rdy,  0);
      check({tag, "_xs"},      xs_of(), xs);
      check({tag, "_ys"},      ys_of(), ys);
      check({tag, "_acc_cnt"}, acc_cnt, cnt);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      rst_n  = 1'b1;
      check("rst_in_rdy",   in_rdy,   1);
      check("rst_acc_val",  acc_val,  0);
      check("rst_acc_cnt",  acc_cnt,  0);
      check("rst_acc_data", acc_data, 0);

      // Basic three-product frame.
      drive(1, 2, 3);
      drive(3, -4, 3);
      check("t1_mid_cnt", acc_cnt, 2);
      check("t1_mid_val", acc_val, 0);
      drive(-10, 5, 3);
      in_val = 1'b0;
      expect_result("t1", -6, 3, 3);
      handshake("t1");

      // Zero length behaves as a single-product frame.
      drive(7, -7, 0);
      in_val = 1'b0;
      expect_result("t2a", 7, -7, 1);
      handshake("t2a");

      // Oversized length clamps to sixteen.
      for (int i = 1; i <= 16; i++) begin
         drive(i, 2 * i, 31);
         if (i == 15) begin
            check("t2b_15_val", acc_val, 0);
            check("t2b_15_cnt", acc_cnt, 15);
         end
      end
      in_val = 1'b0;
      expect_result("t2b", 136, 272, 16);
      handshake("t2b");

      // Full-scale products over a maximum-length frame.
      for (int i = 0; i < 16; i++) drive(-32768, 32767, 16);
      in_val = 1'b0;
      expect_result("t3", -524288, 524272, 16);
      handshake("t3");

      // Result held under backpressure while new input is offered.
      drive(100, -50, 2);
      drive(20, 30, 2);
      in_val  = 1'b1;
      in_data = {IW'(999), IW'(999)};
      acc_len = (AE + 1)'(1);
      for (int k = 0; k < 5; k++) begin
         expect_result("t4_hold", 120, -20, 2);
         @(negedge clk);
      end
      acc_rdy = 1'b1;
      @(negedge clk);
      acc_rdy = 1'b0;
      check("t4_after_hs_in_rdy", in_rdy, 1);
      check("t4_after_hs_cnt",    acc_cnt, 0);
      check("t4_after_hs_xs",     xs_of(), 120);
      @(negedge clk);
      in_val = 1'b0;
      expect_result("t4_next", 999, 999, 1);
      handshake("t4");

      // Software reset mid-frame discards the partial sum.
      drive(1, 1, 4);
      drive(2, 2, 4);
      check("t5_mid_cnt", acc_cnt, 2);
      sw_rst  = 1'b1;
      in_val  = 1'b1;
      in_data = {IW'(3), IW'(3)};
      @(negedge clk);
      sw_rst = 1'b0;
      in_val = 1'b0;
      check("t5_cnt",      acc_cnt,  0);
      check("t5_in_rdy",   in_rdy,   1);
      check("t5_acc_val",  acc_val,  0);
      check("t5_acc_data", acc_data, 0);
      drive(5, 5, 2);
      drive(1, 1, 2);
      in_val = 1'b0;
      expect_result("t5", 6, 6, 2);

      // Asynchronous reset while holding a result acts before any clock edge.
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_acc_val",  acc_val,  0);
      check("t6_acc_data", acc_data, 0);
      check("t6_in_rdy",   in_rdy,   1);
      check("t6_acc_cnt",  acc_cnt,  0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(-3, 4, 1);
      in_val = 1'b0;
      expect_result("t6_after", -3, 4, 1);
      handshake("t6");

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/comp_acc.md
# comp_acc

Complex accumulator stage placed directly downstream of the complex multiplier. It consumes the multiplier's sign-extended {xr,yr} result stream over a valid/ready interface and sums a frame of `acc_len` consecutive complex products, forming a complex dot product. It then presents the wide complex sum on a second valid/ready interface. It adds no backpressure beyond holding the finished sum until it is accepted.

## Interface
- `DWIDTH`, 8, multiplier operand width. Input field width is `IW = 2*DWIDTH+2`.
- `ACC_EXT`, 4, accumulator guard bits. Accumulator width is `AW = IW+ACC_EXT`; maximum frame length is `2^ACC_EXT`.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `sw_rst` in 1: software reset, synchronous, active-high.
- `acc_len` in `ACC_EXT+1`: frame length, sampled on the first accepted input of each frame.
- `in_val` in 1: input product valid.
- `in_rdy` out 1: input product ready.
- `in_data` in `2*IW`: `{xr,yr}` with `xr` in the upper half; both fields are two's complement.
- `acc_val` out 1: accumulated result valid.
- `acc_rdy` in 1: accumulated result ready.
- `acc_data` out `2*AW`: `{xs,ys}` with `xs` in the upper half; both fields are two's complement.
- `acc_cnt` out `ACC_EXT+1`: number of products accepted so far in the current frame (status).

## Operation
- States:
  - IDLE: waiting for the first product of a frame.
  - ACC: mid-frame.
  - OUT: holding the result.
- `in_rdy` = 1 in IDLE and ACC; `in_rdy` = 0 in OUT. A transfer occurs on `in_val & in_rdy`.
- Accepted input in IDLE:
  - latch `L = clamp(acc_len)`, where 0 → 1 and values above `2^ACC_EXT` → `2^ACC_EXT`;
  - load the accumulators with the sign-extended input;
  - set `acc_cnt` = 1;
  - go to OUT if `L` = 1, otherwise go to ACC.
- Accepted input in ACC:
  - add the sign-extended input into `xs` and `ys`;
  - increment `acc_cnt`;
  - go to OUT when the new count equals `L`.
- OUT:
  - `acc_val` = 1, and `acc_data` is held stable;
  - on `acc_val & acc_rdy`, go to IDLE and clear `acc_cnt` to 0;
  - the accumulators keep their value until they are reloaded by the next first input.
- Arithmetic: each `IW`-bit field is sign-extended to `AW` bits, with addition modulo `2^AW`. Overflow is impossible for in-range multiplier outputs and frames up to `2^ACC_EXT` long, so no saturation is applied.
- `acc_len` changes mid-frame are ignored; the latched `L` governs the frame.
- `sw_rst` takes priority over every transfer in the same cycle. It forces the same state as `rst_n`.
- Reset values (both `rst_n` and `sw_rst`):
  - state IDLE;
  - `in_rdy` = 1, `acc_val` = 0;
  - `acc_data` = 0, `acc_cnt` = 0, `L` = 1.
- Reset mid-frame discards the partial sum. The next accepted input starts a new frame.

## Timing
- All outputs are registered except `in_rdy`, which is decoded from registered state only. There is no combinational path from `in_val` or `acc_rdy` to any output.
- Throughput is one product per cycle while in IDLE or ACC.
- Latency: `acc_val` rises on the cycle after the `L`-th input is accepted.
- `in_rdy` falls in that same cycle and returns to 1 in the cycle after `acc_val & acc_rdy`. This gives one bubble cycle per frame.
- `acc_val` does not drop without a handshake. If `acc_rdy` is held 0, the result is held indefinitely.
- `acc_rdy` asserted while `acc_val` = 0 has no effect.

## Structure
- Package `comp_pkg`:
  - width localparams/functions `IW(DWIDTH)` and `AW(DWIDTH,ACC_EXT)`;
  - state enum `{IDLE, ACC, OUT}`;
  - the `clamp_len` function.
- Sub-module `comp_acc_lane`: one signed `AW`-bit accumulator with `load`/`add`/`clr` controls, instantiated twice (real and imaginary lanes).
- The FSM, counter and length latch live in the top level.

## Test plan
All scenarios use `DWIDTH`=8, `ACC_EXT`=4.
1. Basic frame: `acc_len`=3, inputs (1,2), (3,−4), (−10,5) back-to-back → `acc_val` one cycle after the third input, with `xs`=−6, `ys`=3, `acc_cnt`=3.
2. Length edge cases:
   - `acc_len`=0 with input (7,−7) → single-product frame, `xs`=7, `ys`=−7;
   - `acc_len`=31 → frame closes after 16 inputs.
3. Maximum magnitude: `acc_len`=16, sixteen inputs of (−32768, 32767) → `xs`=−524288, `ys`=524272, no wrap.
4. Backpressure: complete a frame, hold `acc_rdy`=0 for 5 cycles while `in_val`=1:
   - `acc_data` stays stable, `in_rdy`=0, and no input is consumed;
   - `acc_rdy`=1 → next frame starts the cycle after the handshake.
5. `sw_rst` mid-frame: `acc_len`=4, assert `sw_rst` after 2 inputs → `acc_cnt`=0 and IDLE. A new frame with `acc_len`=2 of (5,5), (1,1) → (6,6).
6. Async reset: assert `rst_n`=0 while in OUT → `acc_val`=0, `acc_data`=0 and `in_rdy`=1 immediately, without waiting for a clock edge.
